// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer.
// Latency: none (types and constants only).
// Backpressure: n/a.
// Contents: opcode and slice-mode constants, FSM states, decoded-op struct.
package alu_seq_pkg;

    // Opcodes presented on Op
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADC  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // Slice mode on AluM
    localparam logic [1:0] M_NAND = 2'd0;
    localparam logic [1:0] M_NOR  = 2'd1;
    localparam logic [1:0] M_SUM  = 2'd2;
    localparam logic [1:0] M_PASS = 2'd3;

    // Where the carry flop starts when an op is accepted
    typedef enum logic [1:0] {
        CSEL_ZERO = 2'd0,
        CSEL_CIN  = 2'd1,
        CSEL_ONE  = 2'd2
    } csel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       ai;
        logic       bi;
        logic [1:0] m;
        logic       arith;
        csel_t      csel;
    } dec_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Opcode decoder: maps an opcode to slice controls and carry handling.
// Latency: purely combinational.
// Backpressure: none.
// Ports: op_i (opcode in), dec_o (Ai, Bi, M, arith flag, initial-carry select).
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] op_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '{ai: 1'b0, bi: 1'b0, m: M_PASS, arith: 1'b0, csel: CSEL_ZERO};
        case (op_i)
            OP_ADD:  dec_o = '{ai: 1'b0, bi: 1'b0, m: M_SUM,  arith: 1'b1, csel: CSEL_ZERO};
            OP_ADC:  dec_o = '{ai: 1'b0, bi: 1'b0, m: M_SUM,  arith: 1'b1, csel: CSEL_CIN};
            // A + ~B + 1: carry out high means no borrow
            OP_SUB:  dec_o = '{ai: 1'b0, bi: 1'b1, m: M_SUM,  arith: 1'b1, csel: CSEL_ONE};
            // De Morgan: NOR of inverted operands is AND, NAND of inverted is OR
            OP_AND:  dec_o = '{ai: 1'b1, bi: 1'b1, m: M_NOR,  arith: 1'b0, csel: CSEL_ZERO};
            OP_OR:   dec_o = '{ai: 1'b1, bi: 1'b1, m: M_NAND, arith: 1'b0, csel: CSEL_ZERO};
            OP_NAND: dec_o = '{ai: 1'b0, bi: 1'b0, m: M_NAND, arith: 1'b0, csel: CSEL_ZERO};
            OP_NOR:  dec_o = '{ai: 1'b0, bi: 1'b0, m: M_NOR,  arith: 1'b0, csel: CSEL_ZERO};
            OP_PASS: dec_o = '{ai: 1'b0, bi: 1'b0, m: M_PASS, arith: 1'b0, csel: CSEL_ZERO};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq16.sv
// Nibble-serial ALU sequencer driving an external 4-bit ALU slice, LS nibble first.
// Latency: Start sampled at edge 0, Done pulses in the cycle after edge NIBBLES.
// Backpressure: Start is only sampled in IDLE; it is ignored while Busy or Done.
// Ports: Start/Op/OpA/OpB/CarryIn request in; Busy/Done/Result/CarryOut/Zero status out;
//        AluA/AluB/AluC/AluAi/AluBi/AluKin/AluM drive the slice; AluOut/AluKout return from it.
module alu_seq16
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   Clk,
    input  logic                   nReset,
    input  logic                   Start,
    input  logic [2:0]             Op,
    input  logic [4*NIBBLES-1:0]   OpA,
    input  logic [4*NIBBLES-1:0]   OpB,
    input  logic                   CarryIn,
    output logic                   Busy,
    output logic                   Done,
    output logic [4*NIBBLES-1:0]   Result,
    output logic                   CarryOut,
    output logic                   Zero,
    output logic [3:0]             AluA,
    output logic [3:0]             AluB,
    output logic [3:0]             AluC,
    output logic                   AluAi,
    output logic                   AluBi,
    output logic                   AluKin,
    output logic [1:0]             AluM,
    input  logic [3:0]             AluOut,
    input  logic                   AluKout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;

    logic [2:0]      dec_op;
    dec_t            dec;

    // In IDLE the decoder looks at the incoming opcode so the initial carry can
    // be chosen at accept time; afterwards it only ever sees the latched opcode.
    assign dec_op = (state_q == ST_IDLE) ? Op : op_q;

    alu_seq_decode u_decode (
        .op_i  (dec_op),
        .dec_o (dec)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= OP_ADD;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cout_d   = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    op_d    = Op;
                    opa_d   = OpA;
                    opb_d   = OpB;
                    idx_d   = '0;
                    state_d = ST_RUN;
                    case (dec.csel)
                        CSEL_CIN: carry_d = CarryIn;
                        CSEL_ONE: carry_d = 1'b1;
                        default:  carry_d = 1'b0;
                    endcase
                end
            end
            ST_RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = AluOut;
                if (dec.arith) begin
                    carry_d = AluKout;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                    cout_d  = dec.arith & AluKout;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Slice drive is live only in RUN; everywhere else the slice sees all zeros.
    always_comb begin
        AluA   = 4'h0;
        AluB   = 4'h0;
        AluC   = 4'h0;
        AluAi  = 1'b0;
        AluBi  = 1'b0;
        AluKin = 1'b0;
        AluM   = M_NAND;
        if (state_q == ST_RUN) begin
            AluA   = opa_q[{idx_q, 2'b00} +: 4];
            AluB   = opb_q[{idx_q, 2'b00} +: 4];
            AluC   = opa_q[{idx_q, 2'b00} +: 4];
            AluAi  = dec.ai;
            AluBi  = dec.bi;
            AluKin = dec.arith & carry_q;
            AluM   = dec.m;
        end
    end

    assign Busy     = (state_q == ST_RUN);
    assign Done     = (state_q == ST_DONE);
    assign Result   = result_q;
    assign CarryOut = cout_q;
    assign Zero     = (result_q == '0);

endmodule

// File: tb/tb_alu_seq16.sv
// Testbench for alu_seq16 with a behavioural 4-bit ALU slice on the Alu* ports.
// Latency: checks Done lands NIBBLES cycles after the Start edge.
// Backpressure: exercises Start held high through RUN/DONE.
module tb_alu_seq16;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic          Clk = 1'b0;
    logic          nReset;
    logic          Start;
    logic [2:0]    Op;
    logic [W-1:0]  OpA, OpB;
    logic          CarryIn;
    logic          Busy, Done, CarryOut, Zero;
    logic [W-1:0]  Result;
    logic [3:0]    AluA, AluB, AluC, AluOut;
    logic          AluAi, AluBi, AluKin, AluKout;
    logic [1:0]    AluM;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    alu_seq16 #(.NIBBLES(N)) dut (
        .Clk(Clk), .nReset(nReset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
        .CarryIn(CarryIn), .Busy(Busy), .Done(Done), .Result(Result),
        .CarryOut(CarryOut), .Zero(Zero), .AluA(AluA), .AluB(AluB), .AluC(AluC),
        .AluAi(AluAi), .AluBi(AluBi), .AluKin(AluKin), .AluM(AluM),
        .AluOut(AluOut), .AluKout(AluKout)
    );

    // Behavioural ALU slice
    always_comb begin
        logic [3:0] sa, sb;
        logic [4:0] sum;
        sa      = AluAi ? ~AluA : AluA;
        sb      = AluBi ? ~AluB : AluB;
        sum     = {1'b0, sa} + {1'b0, sb} + {4'b0, AluKin};
        AluOut  = 4'h0;
        AluKout = 1'b0;
        case (AluM)
            2'd0: AluOut = ~(sa & sb);
            2'd1: AluOut = ~(sa | sb);
            2'd2: begin AluOut = sum[3:0]; AluKout = sum[4]; end
            default: AluOut = AluC;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic; returns {carry_out, result}
    function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic c);
        int unsigned ua, ub, s;
        ua = a;
        ub = b;
        case (op)
            3'd0: begin s = ua + ub;          return {s[W], s[W-1:0]}; end
            3'd1: begin s = ua + ub + c;      return {s[W], s[W-1:0]}; end
            3'd2: begin s = (ua - ub) & 32'hFFFF; return {(ua >= ub), s[W-1:0]}; end
            3'd3: return {1'b0, a & b};
            3'd4: return {1'b0, a | b};
            3'd5: return {1'b0, ~(a & b)};
            3'd6: return {1'b0, ~(a | b)};
            default: return {1'b0, a};
        endcase
    endfunction

    // Waits (bounded) for Done from the negedge after the Start edge.
    task automatic wait_done(input logic [2:0] op, output int lat, output int busy_n,
                             output logic kin_bad, output logic seen);
        lat = 0; busy_n = 0; kin_bad = 1'b0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Done) begin
                seen = 1'b1;
                break;
            end
            if (Busy) busy_n++;
            if (Busy && op >= 3'd3 && AluKin) kin_bad = 1'b1;
            lat++;
            @(negedge Clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] exp_r, input logic exp_co, input logic timing);
        int lat, busy_n;
        logic kin_bad, seen;
        @(negedge Clk);
        Start = 1'b1; Op = op; OpA = a; OpB = b; CarryIn = c;
        @(negedge Clk);
        // Scramble inputs after acceptance: the result must use latched values
        Start = 1'b0; Op = 3'($urandom); OpA = W'($urandom); OpB = W'($urandom);
        CarryIn = 1'($urandom);
        wait_done(op, lat, busy_n, kin_bad, seen);
        chk({tag, "_done"}, 32'(seen), 32'd1);
        if (timing) begin
            chk({tag, "_latency"}, 32'(lat), 32'(N));
            chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(N));
        end
        chk({tag, "_result"}, 32'(Result), 32'(exp_r));
        chk({tag, "_cout"}, 32'(CarryOut), 32'(exp_co));
        chk({tag, "_zero"}, 32'(Zero), 32'(exp_r == '0));
        if (op >= 3'd3) chk({tag, "_kin"}, 32'(kin_bad), 32'd0);
        @(negedge Clk);
        chk({tag, "_done_one_cycle"}, 32'(Done), 32'd0);
    endtask

    initial begin
        int lat, busy_n;
        logic kin_bad, seen;
        logic [W:0] m;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        logic rc;

        nReset = 1'b0; Start = 1'b0; Op = '0; OpA = '0; OpB = '0; CarryIn = 1'b0;
        #1;
        chk("rst_result", 32'(Result), 32'd0);
        chk("rst_busy_done", 32'({Busy, Done, CarryOut}), 32'd0);
        chk("rst_zero", 32'(Zero), 32'd1);
        chk("rst_alu", 32'({AluA, AluB, AluC, AluAi, AluBi, AluKin, AluM}), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        nReset = 1'b1;

        // Directed cases with hand-derived expectations
        run_op("add_ff",   3'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1);
        run_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("adc_cin",  3'd1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op("sub_bor",  3'd2, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        run_op("sub_eq",   3'd2, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("and",      3'd3, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0);
        run_op("or",       3'd4, 16'hF0F0, 16'h3C3C, 1'b1, 16'hFCFC, 1'b0, 1'b0);
        run_op("nand",     3'd5, 16'hF0F0, 16'h3C3C, 1'b1, 16'hCFCF, 1'b0, 1'b0);
        run_op("nor",      3'd6, 16'hF0F0, 16'h3C3C, 1'b1, 16'h0303, 1'b0, 1'b1);
        run_op("pass",     3'd7, 16'hF0F0, 16'h3C3C, 1'b1, 16'hF0F0, 1'b0, 1'b0);

        // Start held high through RUN with OpA changed mid-operation
        @(negedge Clk);
        Start = 1'b1; Op = 3'd0; OpA = 16'h1111; OpB = 16'h2222; CarryIn = 1'b0;
        @(negedge Clk);
        OpA = 16'hAAAA;
        wait_done(3'd0, lat, busy_n, kin_bad, seen);
        chk("hold_done", 32'(seen), 32'd1);
        chk("hold_latency", 32'(lat), 32'(N));
        chk("hold_result", 32'(Result), 32'h3333);
        @(negedge Clk);
        chk("hold_idle_not_busy", 32'(Busy), 32'd0);
        chk("hold_single_done", 32'(Done), 32'd0);
        @(negedge Clk);
        Start = 1'b0;
        wait_done(3'd0, lat, busy_n, kin_bad, seen);
        chk("hold_next_done", 32'(seen), 32'd1);
        chk("hold_next_result", 32'(Result), 32'hCCCC);
        @(negedge Clk);

        // Reset asserted while the third nibble is being processed
        @(negedge Clk);
        Start = 1'b1; Op = 3'd0; OpA = 16'h1234; OpB = 16'h1111; CarryIn = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("mid_busy", 32'(Busy), 32'd1);
        nReset = 1'b0;
        #1;
        chk("mid_rst_flags", 32'({Busy, Done, CarryOut}), 32'd0);
        chk("mid_rst_result", 32'(Result), 32'd0);
        chk("mid_rst_zero", 32'(Zero), 32'd1);
        chk("mid_rst_alu", 32'({AluA, AluB, AluC, AluAi, AluBi, AluKin, AluM}), 32'd0);
        @(negedge Clk);
        nReset = 1'b1;
        run_op("post_rst_add", 3'd0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b1);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = W'($urandom);
            rb  = (i % 8 == 0) ? ra : W'($urandom);
            rc  = 1'($urandom);
            m   = ref_op(rop, ra, rb, rc);
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rc, m[W-1:0], m[W], 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
